seq_multiplier: RTL

Parametrised sequential shift-add multiplier. It is the operand-fed, width-generic successor of the team's fixed 8x8 `Multipiler`. It takes two WIDTH-bit operands on a start pulse and retires one multiplier bit per clock. It supports unsigned and two's-complement signed modes and returns a 2*WIDTH-bit product with a one-cycle `done` pulse. It sits behind a controller or testbench that drives `start` and samples `data_out` on `done`.

---
 rtl/seq_multiplier.sv | 90 +++++++++
 1 files changed

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one multiplier bit per clock, unsigned or
// two's-complement operands, 2*WIDTH-bit product with a one-cycle done pulse.
module seq_multiplier #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STEP_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [STEP_W-1:0]    step,
  output logic [2*WIDTH-1:0]   data_out
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]    acc;
  logic             neg;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [PW-1:0]    addend;

  // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) read unsigned.
  always_comb begin
    a_mag  = a;
    b_mag  = b;
    if (signed_mode && a[WIDTH-1]) a_mag = ~a + WIDTH'(1);
    if (signed_mode && b[WIDTH-1]) b_mag = ~b + WIDTH'(1);
    addend = PW'(mcand) << step;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      neg      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      step     <= '0;
      data_out <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc    <= '0;
            step   <= '0;
            busy   <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          if (mplier[0]) acc <= acc + addend;
          mplier <= mplier >> 1;
          step   <= step + STEP_W'(1);
          if (step == LAST_STEP) state <= SIGN;
        end
        SIGN: begin
          data_out <= neg ? (~acc + PW'(1)) : acc;
          done     <= 1'b1;
          step     <= '0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
